// File: rtl/freq_gate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : freq_gate_ctrl
//  Brief    : Gate / settle / latch / clear sequencer with auto-ranging for
//             the 8-digit BCD frequency counter.
//  Revision : 1.0  initial release
// ============================================================================
module freq_gate_ctrl #(
    parameter int GATE_CYC0 = 50_000_000,
    parameter int GATE_CYC1 = 5_000_000,
    parameter int GATE_CYC2 = 500_000,
    parameter int SETTLE    = 4,
    parameter int TMR_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic       auto_rng,
    input  logic [1:0] rng_sel,
    input  logic       cnt_ovf,
    input  logic       cnt_low,
    output logic       gate,
    output logic       clr_stb,
    output logic       latch_stb,
    output logic       done,
    output logic       busy,
    output logic [1:0] rng,
    output logic       ovf_flag
);

    // Timer is loaded with (length - 1) and runs down to zero.
    localparam logic [TMR_W-1:0] c_GATE0_LAST  = TMR_W'(GATE_CYC0 - 1);
    localparam logic [TMR_W-1:0] c_GATE1_LAST  = TMR_W'(GATE_CYC1 - 1);
    localparam logic [TMR_W-1:0] c_GATE2_LAST  = TMR_W'(GATE_CYC2 - 1);
    localparam logic [TMR_W-1:0] c_SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] c_TMR_ONE     = TMR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_GATE  = 3'd2,
        S_HOLD  = 3'd3,
        S_LATCH = 3'd4,
        S_EVAL  = 3'd5
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_gate;
    logic             r_clr_stb;
    logic             r_latch_stb;
    logic             r_done;
    logic             r_busy;
    logic [1:0]       r_rng;
    logic             r_ovf_flag;
    logic             r_ovf_seen;
    logic             r_low;

    logic [1:0]       w_sel_rng;
    logic [1:0]       w_auto_rng;
    logic [TMR_W-1:0] w_gate_last;
    logic             w_tmr_zero;
    logic             w_rearm;

    assign w_sel_rng  = (rng_sel == 2'd3) ? 2'd2 : rng_sel;
    assign w_tmr_zero = (r_timer == '0);
    assign w_rearm    = cont & start;

    always_comb begin
        w_gate_last = c_GATE2_LAST;
        case (r_rng)
            2'd0:    w_gate_last = c_GATE0_LAST;
            2'd1:    w_gate_last = c_GATE1_LAST;
            default: w_gate_last = c_GATE2_LAST;
        endcase
    end

    // Overflow takes precedence over underrange; both saturate at the ends.
    always_comb begin
        w_auto_rng = r_rng;
        if (r_ovf_seen) begin
            if (r_rng < 2'd2) begin
                w_auto_rng = r_rng + 2'd1;
            end
        end else if (r_low) begin
            if (r_rng > 2'd0) begin
                w_auto_rng = r_rng - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_gate      <= 1'b0;
            r_clr_stb   <= 1'b0;
            r_latch_stb <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_rng       <= 2'd0;
            r_ovf_flag  <= 1'b0;
            r_ovf_seen  <= 1'b0;
            r_low       <= 1'b0;
        end else if (stop && (r_state != S_IDLE)) begin
            // Abort: range and last overflow result survive.
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_gate      <= 1'b0;
            r_clr_stb   <= 1'b0;
            r_latch_stb <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state   <= S_CLEAR;
                        r_clr_stb <= 1'b1;
                        r_busy    <= 1'b1;
                        if (!auto_rng) begin
                            r_rng <= w_sel_rng;
                        end
                    end
                end
                S_CLEAR: begin
                    r_clr_stb  <= 1'b0;
                    r_gate     <= 1'b1;
                    r_timer    <= w_gate_last;
                    r_ovf_seen <= 1'b0;
                    r_state    <= S_GATE;
                end
                S_GATE: begin
                    r_ovf_seen <= r_ovf_seen | cnt_ovf;
                    if (w_tmr_zero) begin
                        r_gate  <= 1'b0;
                        r_timer <= c_SETTLE_LAST;
                        r_state <= S_HOLD;
                    end else begin
                        r_timer <= r_timer - c_TMR_ONE;
                    end
                end
                S_HOLD: begin
                    r_ovf_seen <= r_ovf_seen | cnt_ovf;
                    if (w_tmr_zero) begin
                        r_latch_stb <= 1'b1;
                        r_state     <= S_LATCH;
                    end else begin
                        r_timer <= r_timer - c_TMR_ONE;
                    end
                end
                S_LATCH: begin
                    r_latch_stb <= 1'b0;
                    r_done      <= 1'b1;
                    r_low       <= cnt_low;
                    r_state     <= S_EVAL;
                end
                S_EVAL: begin
                    r_done     <= 1'b0;
                    r_ovf_flag <= r_ovf_seen;
                    if (auto_rng) begin
                        r_rng <= w_auto_rng;
                    end
                    if (w_rearm) begin
                        r_state   <= S_CLEAR;
                        r_clr_stb <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_timer     <= '0;
                    r_gate      <= 1'b0;
                    r_clr_stb   <= 1'b0;
                    r_latch_stb <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign gate      = r_gate;
    assign clr_stb   = r_clr_stb;
    assign latch_stb = r_latch_stb;
    assign done      = r_done;
    assign busy      = r_busy;
    assign rng       = r_rng;
    assign ovf_flag  = r_ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_freq_gate_ctrl
//  Brief    : Self-checking bench for freq_gate_ctrl (timeline model + directed).
//  Revision : 1.0  initial release
// ============================================================================
module tb_freq_gate_ctrl;

    localparam int G0 = 100;
    localparam int G1 = 10;
    localparam int G2 = 1;
    localparam int ST = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic       auto_rng = 1'b0;
    logic [1:0] rng_sel = 2'd0;
    logic       cnt_ovf = 1'b0;
    logic       cnt_low = 1'b0;
    logic       gate, clr_stb, latch_stb, done, busy, ovf_flag;
    logic [1:0] rng;

    freq_gate_ctrl #(
        .GATE_CYC0(G0), .GATE_CYC1(G1), .GATE_CYC2(G2), .SETTLE(ST), .TMR_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .auto_rng(auto_rng), .rng_sel(rng_sel), .cnt_ovf(cnt_ovf), .cnt_low(cnt_low),
        .gate(gate), .clr_stb(clr_stb), .latch_stb(latch_stb), .done(done),
        .busy(busy), .rng(rng), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a measurement is a timeline indexed by m_t = edges since start.
    bit m_valid = 1'b0;
    bit m_active = 1'b0;
    int m_t = 0;
    int m_G = G0;
    int m_rng = 0;
    bit m_seen = 1'b0;
    bit m_flag = 1'b0;
    bit m_low = 1'b0;

    function automatic int glen(input int r);
        return (r == 0) ? G0 : ((r == 1) ? G1 : G2);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1; m_active = 1'b0; m_rng = 0; m_flag = 1'b0; m_seen = 1'b0; m_t = 0;
        end else if (m_active && stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1;
                m_t = 0;
                if (!auto_rng) m_rng = (rng_sel > 2'd2) ? 2 : int'(rng_sel);
                m_G = glen(m_rng);
                m_seen = 1'b0;
            end
        end else begin
            if (m_t >= 1 && m_t <= m_G + ST && cnt_ovf) m_seen = 1'b1;
            if (m_t == m_G + ST + 1) m_low = cnt_low;
            if (m_t == m_G + ST + 2) begin
                m_flag = m_seen;
                if (auto_rng) begin
                    if (m_seen) m_rng = (m_rng < 2) ? m_rng + 1 : 2;
                    else if (m_low) m_rng = (m_rng > 0) ? m_rng - 1 : 0;
                end
                if (cont && start) begin
                    m_t = 0; m_seen = 1'b0; m_G = glen(m_rng);
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
        end
    end

    // Event counters used by the directed checks.
    int  cyc = 0, n_gate = 0, n_clr = 0, n_latch = 0, n_done = 0, n_idle = 0;
    int  fall_cyc = 0, latch_cyc = 0, done_cyc = 0;
    bit  prev_gate = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (gate === 1'b1) n_gate++;
        if (clr_stb === 1'b1) n_clr++;
        if (latch_stb === 1'b1) begin n_latch++; latch_cyc = cyc; end
        if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (busy === 1'b0) n_idle++;
        if (prev_gate && gate === 1'b0) fall_cyc = cyc;
        prev_gate = (gate === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("clr_stb",   32'(clr_stb),   32'(m_active && m_t == 0));
                chk("gate",      32'(gate),      32'(m_active && m_t >= 1 && m_t <= m_G));
                chk("latch_stb", 32'(latch_stb), 32'(m_active && m_t == m_G + ST + 1));
                chk("done",      32'(done),      32'(m_active && m_t == m_G + ST + 2));
                chk("busy",      32'(busy),      32'(m_active));
                chk("rng",       32'(rng),       32'(m_rng));
                chk("ovf_flag",  32'(ovf_flag),  32'(m_flag));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // which: 0 = gate high, 1 = gate low, 2 = done
    task automatic wait_until(input int which, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            case (which)
                0:       hit = (gate === 1'b1);
                1:       hit = (gate === 1'b0);
                default: hit = (done === 1'b1);
            endcase
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic measure(input bit ovf, input bit low);
        cnt_ovf = ovf;
        cnt_low = low;
        pulse_start();
        wait_until(2, 150, "measure_done");
        tick();
        cnt_ovf = 1'b0;
        cnt_low = 1'b0;
    endtask

    int s_gate, s_clr, s_latch, s_done, s_idle;
    task automatic snap();
        s_gate = n_gate; s_clr = n_clr; s_latch = n_latch; s_done = n_done; s_idle = n_idle;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            compare_loop();
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_gate", 32'(gate), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rng", 32'(rng), 0);
        chk("rst_ovf_flag", 32'(ovf_flag), 0);
        rst_n = 1'b1;
        tick();

        // 1: manual range 1, single start pulse
        auto_rng = 1'b0; rng_sel = 2'd1;
        snap();
        pulse_start();
        wait_until(2, 40, "t1_done");
        tick();
        chk("t1_gate_len", 32'(n_gate - s_gate), 10);
        chk("t1_clr_cnt", 32'(n_clr - s_clr), 1);
        chk("t1_latch_cnt", 32'(n_latch - s_latch), 1);
        chk("t1_done_cnt", 32'(n_done - s_done), 1);
        chk("t1_settle", 32'(latch_cyc - fall_cyc), 2);
        chk("t1_done_after_latch", 32'(done_cyc - latch_cyc), 1);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_rng", 32'(rng), 1);

        // 2 + 4: auto from range 0, overflow in gate cycle 50, continuous
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t2_rng_reset", 32'(rng), 0);
        auto_rng = 1'b1; cont = 1'b1; start = 1'b1;
        wait_until(0, 10, "t2_gate_rise");
        repeat (49) tick();
        cnt_ovf = 1'b1; tick(); cnt_ovf = 1'b0;
        snap();
        wait_until(2, 200, "t2_done1");
        tick();
        chk("t4_clr_after_eval", 32'(clr_stb), 1);
        chk("t4_no_idle", 32'(n_idle - s_idle), 0);
        chk("t2_ovf_flag", 32'(ovf_flag), 1);
        chk("t2_rng_up", 32'(rng), 1);
        snap();
        start = 1'b0;
        wait_until(2, 40, "t2_done2");
        chk("t2_gate_len_r1", 32'(n_gate - s_gate), 10);
        tick();
        chk("t4_idle_after", 32'(busy), 0);
        chk("t2_ovf_clear", 32'(ovf_flag), 0);
        cont = 1'b0;

        // 3: auto-range walk and saturation
        measure(1'b1, 1'b0); chk("t3_up_to2", 32'(rng), 2);
        measure(1'b1, 1'b0); chk("t3_sat2", 32'(rng), 2);
        measure(1'b0, 1'b1); chk("t3_down1", 32'(rng), 1);
        measure(1'b0, 1'b1); chk("t3_down0", 32'(rng), 0);
        measure(1'b0, 1'b1); chk("t3_sat0", 32'(rng), 0);
        measure(1'b1, 1'b0); chk("t3_up1", 32'(rng), 1);
        measure(1'b1, 1'b1); chk("t3_ovf_wins", 32'(rng), 2);
        chk("t3_flag", 32'(ovf_flag), 1);

        // 5: stop in gate cycle 5, then stop blocking start in IDLE
        auto_rng = 1'b0; rng_sel = 2'd1;
        pulse_start();
        wait_until(0, 10, "t5_gate_rise");
        repeat (4) tick();
        stop = 1'b1;
        snap();
        tick();
        chk("t5_gate_drop", 32'(gate), 0);
        chk("t5_idle", 32'(busy), 0);
        start = 1'b1;
        repeat (2) tick();
        chk("t5_stop_blocks", 32'(busy), 0);
        start = 1'b0; stop = 1'b0;
        repeat (20) tick();
        chk("t5_no_latch", 32'(n_latch - s_latch), 0);
        chk("t5_no_done", 32'(n_done - s_done), 0);
        chk("t5_rng_kept", 32'(rng), 1);
        chk("t5_flag_kept", 32'(ovf_flag), 1);

        // 6: reset during HOLD, then manual rng_sel=3
        rng_sel = 2'd0;
        pulse_start();
        wait_until(0, 10, "t6_gate_rise");
        wait_until(1, 120, "t6_gate_fall");
        snap();
        rst_n = 1'b0;
        tick();
        chk("t6_gate", 32'(gate), 0);
        chk("t6_latch", 32'(latch_stb), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rng", 32'(rng), 0);
        chk("t6_flag", 32'(ovf_flag), 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t6_no_latch", 32'(n_latch - s_latch), 0);
        chk("t6_no_done", 32'(n_done - s_done), 0);
        rng_sel = 2'd3;
        snap();
        pulse_start();
        wait_until(2, 20, "t6_done");
        tick();
        chk("t6_gate_len_r2", 32'(n_gate - s_gate), 1);
        chk("t6_rng_sel3", 32'(rng), 2);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
